// File: rtl/seq_pattern_detector_pkg.sv
// seq_pattern_detector_pkg: shared defaults and cfg_addr decode helpers for
// the sequence pattern detector.
package seq_pattern_detector_pkg;

  localparam int unsigned DEF_SYM_W   = 3;
  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_CNT_W   = 16;

  // cfg_addr value selecting pat_len; pattern slots occupy 0..max_len-1
  function automatic int unsigned len_addr(input int unsigned max_len);
    return max_len;
  endfunction

  localparam int unsigned LEN_ADDR = len_addr(DEF_MAX_LEN);

  function automatic int unsigned addr_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int unsigned wdata_w(input int unsigned sym_w, input int unsigned max_len);
    return (sym_w > addr_w(max_len)) ? sym_w : addr_w(max_len);
  endfunction

endpackage

// File: rtl/seq_pattern_history.sv
// seq_pattern_history: shift register of the last DEPTH accepted symbols
// plus a fill counter saturating at DEPTH.
//   clk, reset_n : clock, async active-low reset
//   i_shift      : shift i_sym in and bump fill
//   i_clear      : zero fill (history contents become don't-care)
//   i_sym        : incoming symbol
//   o_hist       : per-slot symbols, slot 0 = most recent
//   o_fill       : number of valid history slots
module seq_pattern_history #(
  parameter int unsigned SYM_W  = 3,
  parameter int unsigned DEPTH  = 7,
  parameter int unsigned FILL_W = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        i_shift,
  input  logic                        i_clear,
  input  logic [SYM_W-1:0]            i_sym,
  output logic [DEPTH-1:0][SYM_W-1:0] o_hist,
  output logic [FILL_W-1:0]           o_fill
);

  logic [DEPTH-1:0][SYM_W-1:0] r_hist;
  logic [FILL_W-1:0]           r_fill;

  // history shift, newest symbol lands in slot 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist <= '0;
    end else if (i_shift) begin
      r_hist[0] <= i_sym;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_hist[i] <= r_hist[i-1];
      end
    end
  end

  // fill counter; clear has priority over shift
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fill <= '0;
    end else if (i_clear) begin
      r_fill <= '0;
    end else if (i_shift && (r_fill != FILL_W'(DEPTH))) begin
      r_fill <= r_fill + FILL_W'(1);
    end
  end

  assign o_hist = r_hist;
  assign o_fill = r_fill;

endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: programmable sequence detector with overlap control.
//   clk, reset_n   : clock, async active-low reset
//   data           : incoming symbol, sampled when data_valid & ~cfg_we
//   overlap        : 1 = overlapping matches, 0 = non-overlapping
//   cfg_we/addr/wdata : write pattern slot (addr < MAX_LEN) or pat_len (addr == MAX_LEN)
//   cnt_clr        : synchronous clear of match_count
//   sequence_found : combinational pulse in the cycle of the final symbol
//   match_count    : saturating match count
// Optional: define SEQ_PATTERN_DETECTOR_MATCH_COUNT_EN to build the match
// counter; otherwise match_count is tied to 0 and cnt_clr is ignored.
module seq_pattern_detector
  import seq_pattern_detector_pkg::*;
#(
  parameter int unsigned SYM_W   = DEF_SYM_W,
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [SYM_W-1:0]                      data,
  input  logic                                  data_valid,
  input  logic                                  overlap,
  input  logic                                  cfg_we,
  input  logic [addr_w(MAX_LEN)-1:0]            cfg_addr,
  input  logic [wdata_w(SYM_W, MAX_LEN)-1:0]    cfg_wdata,
  input  logic                                  cnt_clr,
  output logic                                  sequence_found,
  output logic [CNT_W-1:0]                      match_count
);

  localparam int unsigned AW      = addr_w(MAX_LEN);
  localparam int unsigned DEPTH   = MAX_LEN - 1;
  localparam int unsigned FILL_W  = $clog2(MAX_LEN);
  localparam int unsigned LEN_SEL = len_addr(MAX_LEN);

  logic [SYM_W-1:0]            r_pat [MAX_LEN];
  logic [AW-1:0]               r_pat_len;
  logic [DEPTH-1:0][SYM_W-1:0] w_hist;
  logic [FILL_W-1:0]           w_fill;
  logic [31:0]                 w_len;
  logic                        w_en;
  logic                        w_last_ok;
  logic                        w_hist_ok;
  logic                        w_fill_ok;
  logic                        w_accept;
  logic                        w_match;
  logic                        w_shift;
  logic                        w_clear;

  // pattern slots and length register; lengths are stored as written
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(MAX_LEN); k++) begin
        r_pat[k] <= '0;
      end
      r_pat_len <= '0;
    end else if (cfg_we) begin
      for (int k = 0; k < int'(MAX_LEN); k++) begin
        if (32'(cfg_addr) == 32'(k)) r_pat[k] <= cfg_wdata[SYM_W-1:0];
      end
      if (32'(cfg_addr) == LEN_SEL) r_pat_len <= cfg_wdata[AW-1:0];
    end
  end

  // comparator: history slot i (age i+1) must equal pat[len-2-i]
  always_comb begin
    w_len     = 32'(r_pat_len);
    w_en      = (w_len >= 32'd2) && (w_len <= MAX_LEN);
    w_last_ok = 1'b0;
    w_hist_ok = 1'b1;
    for (int k = 0; k < int'(MAX_LEN); k++) begin
      if (32'(k + 1) == w_len) w_last_ok = (data == r_pat[k]);
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      for (int k = 0; k < int'(MAX_LEN); k++) begin
        if ((32'(i + k + 2) == w_len) && (w_hist[i] != r_pat[k])) w_hist_ok = 1'b0;
      end
    end
    w_fill_ok = (32'(w_fill) + 32'd1) >= w_len;
    w_accept  = data_valid & ~cfg_we;
    w_match   = reset_n & w_accept & w_en & w_last_ok & w_hist_ok & w_fill_ok;
    // a non-overlapping match consumes its symbols instead of shifting
    w_shift   = w_accept & ~(w_match & ~overlap);
    w_clear   = cfg_we | (w_match & ~overlap);
  end

  seq_pattern_history #(
    .SYM_W  (SYM_W),
    .DEPTH  (DEPTH),
    .FILL_W (FILL_W)
  ) u_history (
    .clk     (clk),
    .reset_n (reset_n),
    .i_shift (w_shift),
    .i_clear (w_clear),
    .i_sym   (data),
    .o_hist  (w_hist),
    .o_fill  (w_fill)
  );

  assign sequence_found = w_match;

`ifdef SEQ_PATTERN_DETECTOR_MATCH_COUNT_EN
  logic [CNT_W-1:0] r_count;

  // saturating match counter; clear beats a coincident match
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (cnt_clr) begin
      r_count <= '0;
    end else if (w_match && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign match_count = r_count;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: directed and randomized checks of
// seq_pattern_detector against a queue-based reference model.
module tb_seq_pattern_detector;

  localparam int SYM_W   = 3;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk        = 1'b0;
  logic             reset_n    = 1'b1;
  logic [SYM_W-1:0] data       = '0;
  logic             data_valid = 1'b0;
  logic             overlap    = 1'b0;
  logic             cfg_we     = 1'b0;
  logic [3:0]       cfg_addr   = '0;
  logic [3:0]       cfg_wdata  = '0;
  logic             cnt_clr    = 1'b0;
  logic             sequence_found;
  logic [CNT_W-1:0] match_count;

  seq_pattern_detector #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .data           (data),
    .data_valid     (data_valid),
    .overlap        (overlap),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .cnt_clr        (cnt_clr),
    .sequence_found (sequence_found),
    .match_count    (match_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_pat [MAX_LEN] = '{default: 0};
  int m_len  = 0;
  int m_fill = 0;
  int m_cnt  = 0;
  int hq [$];          // accepted symbols, newest at the back

  function automatic bit exp_found();
    if (!reset_n || !data_valid || cfg_we) return 1'b0;
    if (m_len < 2 || m_len > MAX_LEN) return 1'b0;
    if (m_fill < m_len - 1) return 1'b0;
    if (int'(data) != m_pat[m_len-1]) return 1'b0;
    for (int k = 0; k < m_len - 1; k++) begin
      if (hq[hq.size() - (m_len - 1) + k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit f;
    if (!reset_n) begin
      m_pat  = '{default: 0};
      m_len  = 0;
      m_fill = 0;
      m_cnt  = 0;
      hq.delete();
    end else begin
      f = exp_found();
`ifdef SEQ_PATTERN_DETECTOR_MATCH_COUNT_EN
      if (cnt_clr) m_cnt = 0;
      else if (f && m_cnt < CNT_MAX) m_cnt++;
`endif
      if (cfg_we) begin
        if (int'(cfg_addr) < MAX_LEN) m_pat[int'(cfg_addr)] = int'(cfg_wdata[SYM_W-1:0]);
        else if (int'(cfg_addr) == MAX_LEN) m_len = int'(cfg_wdata);
        m_fill = 0;
      end else if (data_valid) begin
        if (f && !overlap) begin
          m_fill = 0;
        end else begin
          hq.push_back(int'(data));
          if (hq.size() > MAX_LEN - 1) void'(hq.pop_front());
          if (m_fill < MAX_LEN - 1) m_fill++;
        end
      end
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_found", int'(sequence_found), int'(exp_found()));
      chk("model_count", int'(match_count), m_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  int leg [MAX_LEN] = '{1, 5, 6, 0, 6, 6, 3, 5};

  task automatic drive(input bit v, input int d, input bit we, input int a, input int wd, input bit clr);
    @(posedge clk);
    #1;
    data_valid = v;
    data       = SYM_W'(d);
    cfg_we     = we;
    cfg_addr   = 4'(a);
    cfg_wdata  = 4'(wd);
    cnt_clr    = clr;
    @(negedge clk);
  endtask

  task automatic sym(input int d);
    drive(1'b1, d, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic wr(input int a, input int wd);
    drive(1'b0, 0, 1'b1, a, wd, 1'b0);
  endtask

  task automatic load_legacy();
    for (int k = 0; k < MAX_LEN; k++) wr(k, leg[k]);
    wr(MAX_LEN, MAX_LEN);
  endtask

  int exp_cnt_lit;
  int ov_exp [5];

  initial begin
`ifdef SEQ_PATTERN_DETECTOR_MATCH_COUNT_EN
    exp_cnt_lit = CNT_MAX;
`else
    exp_cnt_lit = 0;
`endif
    // reset state, with a valid symbol presented during reset
    #2 reset_n = 1'b0;
    chk_en     = 1'b1;
    data_valid = 1'b1;
    data       = 3'd5;
    @(negedge clk);
    chk("reset_found", int'(sequence_found), 0);
    chk("reset_count", int'(match_count), 0);
    data_valid = 1'b0;
    #3 reset_n = 1'b1;

    // legacy pattern, one pulse on the eighth symbol
    overlap = 1'b0;
    load_legacy();
    for (int k = 0; k < MAX_LEN; k++) begin
      sym(leg[k]);
      chk($sformatf("legacy_sym%0d", k), int'(sequence_found), (k == MAX_LEN - 1) ? 1 : 0);
    end

    // data_valid gaps mid-pattern do not break the match
    for (int k = 0; k < MAX_LEN; k++) begin
      sym(leg[k]);
      chk($sformatf("gap_sym%0d", k), int'(sequence_found), (k == MAX_LEN - 1) ? 1 : 0);
      if (k == 3) begin
        idle();
        chk("gap_idle0", int'(sequence_found), 0);
        idle();
        chk("gap_idle1", int'(sequence_found), 0);
      end
    end

    // write coinciding with final symbol wins and empties the history
    for (int k = 0; k < MAX_LEN - 1; k++) sym(leg[k]);
    drive(1'b1, leg[MAX_LEN-1], 1'b1, 0, leg[0], 1'b0);
    chk("cfg_win_found", int'(sequence_found), 0);
    sym(leg[MAX_LEN-1]);
    chk("cfg_fill_zero", int'(sequence_found), 0);

    // asynchronous reset mid-pattern
    for (int k = 0; k < 5; k++) sym(leg[k]);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_found", int'(sequence_found), 0);
    chk("midrst_count", int'(match_count), 0);
    sym(leg[5]);
    chk("midrst_found_hold", int'(sequence_found), 0);
    #1 reset_n = 1'b1;
    for (int k = 0; k < MAX_LEN; k++) begin
      sym(leg[k]);
      chk($sformatf("len0_sym%0d", k), int'(sequence_found), 0);
    end
    load_legacy();
    for (int k = 0; k < MAX_LEN; k++) begin
      sym(leg[k]);
      chk($sformatf("reload_sym%0d", k), int'(sequence_found), (k == MAX_LEN - 1) ? 1 : 0);
    end

    // overlap vs non-overlap on 010,010,010
    wr(0, 2); wr(1, 2); wr(2, 2); wr(MAX_LEN, 3);
    overlap = 1'b1;
    ov_exp = '{0, 0, 1, 1, 1};
    for (int k = 0; k < 5; k++) begin
      sym(2);
      chk($sformatf("ovl1_sym%0d", k), int'(sequence_found), ov_exp[k]);
    end
    overlap = 1'b0;
    wr(MAX_LEN, 3);
    ov_exp = '{0, 0, 1, 0, 0};
    for (int k = 0; k < 5; k++) begin
      sym(2);
      chk($sformatf("ovl0_sym%0d", k), int'(sequence_found), ov_exp[k]);
    end

    // counter saturation and clear coinciding with a match
    drive(1'b0, 0, 1'b0, 0, 0, 1'b1);
    overlap = 1'b1;
    wr(MAX_LEN, 3);
    for (int k = 0; k < 7; k++) sym(2);
    idle();
    chk("cnt_saturate", int'(match_count), exp_cnt_lit);
    drive(1'b1, 2, 1'b0, 0, 0, 1'b1);
    chk("cnt_clr_match_found", int'(sequence_found), 1);
    idle();
    chk("cnt_clr_match", int'(match_count), 0);

    // disabled lengths
    wr(MAX_LEN, 1);
    for (int k = 0; k < 10; k++) begin
      sym(2);
      chk("len1_found", int'(sequence_found), 0);
    end
    wr(MAX_LEN, 9);
    for (int k = 0; k < 20; k++) begin
      sym(int'($urandom_range(0, 7)));
      chk("len9_found", int'(sequence_found), 0);
    end

    // randomized traffic, compared every cycle by the model process
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        int lens [8];
        lens = '{0, 1, 2, 3, 4, 9, 2, 3};
        for (int k = 0; k < MAX_LEN; k++) wr(k, int'($urandom_range(0, 1)));
        wr(MAX_LEN, lens[$urandom_range(0, 7)]);
      end
      if ($urandom_range(0, 99) < 5) overlap = ~overlap;
      drive($urandom_range(0, 99) < 75,
            int'($urandom_range(0, 1)),
            $urandom_range(0, 99) < 3,
            int'($urandom_range(0, 9)),
            int'($urandom_range(0, 9)),
            $urandom_range(0, 99) < 3);
      if ($urandom_range(0, 999) < 3) begin
        #2 reset_n = 1'b0;
        sym(1);
        #2 reset_n = 1'b1;
      end
    end

    idle();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
